// File: rtl/broadsync_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : broadsync_cfg_seq
// Purpose  : Programs one broadsync frame over the CSR bus. It disables the
//            frame, writes the timing and lock/accuracy registers, and then
//            re-enables the frame. It then polls for completion and reads back
//            the received status. Supports timeout and abort outcomes.
// Revision : 1.0 - initial release
// ============================================================================
module broadsync_cfg_seq #(
    parameter int FRAC_NS_WIDTH = 30,
    parameter int NS_WIDTH      = 30,
    parameter int S_WIDTH       = 48,
    parameter int POLL_GAP      = 16,
    parameter int POLL_TIMEOUT  = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [FRAC_NS_WIDTH-1:0] cfg_toggle_frac_ns,
    input  logic [NS_WIDTH-1:0]      cfg_toggle_ns,
    input  logic [S_WIDTH-1:0]       cfg_toggle_s,
    input  logic [FRAC_NS_WIDTH-1:0] cfg_half_frac_ns,
    input  logic [NS_WIDTH-1:0]      cfg_half_ns,
    input  logic [S_WIDTH-1:0]       cfg_offset_s,
    input  logic                     cfg_lock_value,
    input  logic [7:0]               cfg_clk_accuracy,
    output logic                     busy,
    output logic                     done,
    output logic                     st_ok,
    output logic                     st_timeout,
    output logic                     st_aborted,
    output logic                     st_frame_error,
    output logic                     st_lock_out,
    output logic [7:0]               st_clk_accuracy,
    output logic                     bus_read,
    output logic                     bus_write,
    output logic [29:0]              bus_address,
    output logic [31:0]              bus_write_data,
    input  logic [31:0]              bus_read_data,
    input  logic                     bus_access_complete
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ACC       = 3'd1,
        S_GAP       = 3'd2,
        S_POLL_WAIT = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    // Which access the shared ACC/GAP engine is currently performing
    typedef enum logic [1:0] {
        PH_WRITE = 2'd0,
        PH_POLL  = 2'd1,
        PH_STAT  = 2'd2,
        PH_STOP  = 2'd3
    } phase_t;

    localparam int PCW = $clog2(POLL_TIMEOUT + 1);
    localparam int WCW = $clog2(POLL_GAP + 1);
    localparam logic [PCW-1:0] C_POLL_MAX  = PCW'(POLL_TIMEOUT);
    localparam logic [WCW-1:0] C_GAP_LAST  = WCW'(POLL_GAP - 1);
    localparam logic [29:0]    C_ADDR_CTRL = 30'd1;
    localparam logic [29:0]    C_ADDR_STAT = 30'd14;
    localparam logic [3:0]     C_LAST_IDX  = 4'd10;

    state_t                   r_state, w_state;
    phase_t                   r_phase, w_phase;
    logic [3:0]               r_idx, w_idx;
    logic [WCW-1:0]           r_wait_cnt, w_wait_cnt;
    logic [PCW-1:0]           r_poll_cnt, w_poll_cnt;
    logic [PCW-1:0]           w_poll_inc;
    logic                     r_poll_hit, w_poll_hit;
    logic                     r_abort_pend, w_abort_pend;
    logic                     w_abort_now;
    logic                     w_go_stop;
    logic                     r_bus_read, w_bus_read;
    logic                     r_bus_write, w_bus_write;
    logic [29:0]              r_bus_addr, w_bus_addr;
    logic [31:0]              r_bus_wdata, w_bus_wdata;
    logic                     r_st_ok, w_st_ok;
    logic                     r_st_timeout, w_st_timeout;
    logic                     r_st_aborted, w_st_aborted;
    logic                     r_st_frame_error, w_st_frame_error;
    logic                     r_st_lock_out, w_st_lock_out;
    logic [7:0]               r_st_clk_acc, w_st_clk_acc;

    logic [FRAC_NS_WIDTH-1:0] r_toggle_frac, r_half_frac;
    logic [NS_WIDTH-1:0]      r_toggle_ns, r_half_ns;
    logic [S_WIDTH-1:0]       r_toggle_s, r_offset_s;
    logic                     r_lock;
    logic [7:0]               r_acc;
    logic [63:0]              w_toggle_s64, w_offset_s64;
    logic [3:0]               w_idx_inc;
    logic [29:0]              w_inc_addr;
    logic [31:0]              w_inc_data;
    logic                     w_accept;
    logic                     w_unused_rd;

    assign w_accept     = (r_state == S_IDLE) && start;
    assign w_toggle_s64 = 64'(r_toggle_s);
    assign w_offset_s64 = 64'(r_offset_s);
    assign w_poll_inc   = r_poll_cnt + PCW'(1);
    assign w_unused_rd  = &{1'b0, bus_read_data[30:10]};

    // Shadow copy of the configuration taken on an accepted start
    always_ff @(posedge clk) begin
        if (reset) begin
            r_toggle_frac <= '0;
            r_toggle_ns   <= '0;
            r_toggle_s    <= '0;
            r_half_frac   <= '0;
            r_half_ns     <= '0;
            r_offset_s    <= '0;
            r_lock        <= 1'b0;
            r_acc         <= '0;
        end else if (w_accept) begin
            r_toggle_frac <= cfg_toggle_frac_ns;
            r_toggle_ns   <= cfg_toggle_ns;
            r_toggle_s    <= cfg_toggle_s;
            r_half_frac   <= cfg_half_frac_ns;
            r_half_ns     <= cfg_half_ns;
            r_offset_s    <= cfg_offset_s;
            r_lock        <= cfg_lock_value;
            r_acc         <= cfg_clk_accuracy;
        end
    end

    // Address and data of the write that follows the current write-list entry
    always_comb begin
        w_idx_inc  = r_idx + 4'd1;
        w_inc_addr = (w_idx_inc == C_LAST_IDX) ? C_ADDR_CTRL : (30'(w_idx_inc) + 30'd1);
        w_inc_data = '0;
        case (w_idx_inc)
            4'd1:    w_inc_data = 32'(r_toggle_frac);
            4'd2:    w_inc_data = 32'(r_toggle_ns);
            4'd3:    w_inc_data = w_toggle_s64[31:0];
            4'd4:    w_inc_data = w_toggle_s64[63:32];
            4'd5:    w_inc_data = 32'(r_half_frac);
            4'd6:    w_inc_data = 32'(r_half_ns);
            4'd7:    w_inc_data = w_offset_s64[31:0];
            4'd8:    w_inc_data = w_offset_s64[63:32];
            4'd9:    w_inc_data = {23'd0, r_lock, r_acc};
            4'd10:   w_inc_data = 32'd1;
            default: w_inc_data = '0;
        endcase
    end

    // Next-state, bus request and outcome logic
    always_comb begin
        w_state          = r_state;
        w_phase          = r_phase;
        w_idx            = r_idx;
        w_wait_cnt       = r_wait_cnt;
        w_poll_cnt       = r_poll_cnt;
        w_poll_hit       = r_poll_hit;
        w_abort_pend     = r_abort_pend;
        w_bus_read       = r_bus_read;
        w_bus_write      = r_bus_write;
        w_bus_addr       = r_bus_addr;
        w_bus_wdata      = r_bus_wdata;
        w_st_ok          = r_st_ok;
        w_st_timeout     = r_st_timeout;
        w_st_aborted     = r_st_aborted;
        w_st_frame_error = r_st_frame_error;
        w_st_lock_out    = r_st_lock_out;
        w_st_clk_acc     = r_st_clk_acc;
        w_go_stop        = 1'b0;
        w_abort_now      = r_abort_pend || (abort && (r_phase != PH_STOP));

        // Abort is remembered so that a short pulse during a long access is not lost
        if ((r_state == S_ACC || r_state == S_GAP || r_state == S_POLL_WAIT) &&
            abort && (r_phase != PH_STOP)) begin
            w_abort_pend = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state          = S_ACC;
                    w_phase          = PH_WRITE;
                    w_idx            = '0;
                    w_poll_cnt       = '0;
                    w_wait_cnt       = '0;
                    w_poll_hit       = 1'b0;
                    w_abort_pend     = 1'b0;
                    w_bus_write      = 1'b1;
                    w_bus_read       = 1'b0;
                    w_bus_addr       = C_ADDR_CTRL;
                    w_bus_wdata      = '0;
                    w_st_ok          = 1'b0;
                    w_st_timeout     = 1'b0;
                    w_st_aborted     = 1'b0;
                    w_st_frame_error = 1'b0;
                    w_st_lock_out    = 1'b0;
                    w_st_clk_acc     = '0;
                end
            end
            S_ACC: begin
                if (bus_access_complete) begin
                    w_state     = S_GAP;
                    w_bus_read  = 1'b0;
                    w_bus_write = 1'b0;
                    if (r_phase == PH_POLL) begin
                        w_poll_hit = bus_read_data[31];
                    end
                    if (r_phase == PH_STAT) begin
                        w_st_clk_acc     = bus_read_data[7:0];
                        w_st_lock_out    = bus_read_data[8];
                        w_st_frame_error = bus_read_data[9];
                    end
                end
            end
            S_GAP: begin
                if (r_phase == PH_STOP) begin
                    w_state = S_DONE;
                end else if (w_abort_now) begin
                    w_go_stop    = 1'b1;
                    w_st_aborted = 1'b1;
                end else begin
                    case (r_phase)
                        PH_WRITE: begin
                            if (r_idx == C_LAST_IDX) begin
                                w_state    = S_POLL_WAIT;
                                w_wait_cnt = '0;
                            end else begin
                                w_idx       = w_idx_inc;
                                w_state     = S_ACC;
                                w_bus_write = 1'b1;
                                w_bus_addr  = w_inc_addr;
                                w_bus_wdata = w_inc_data;
                            end
                        end
                        PH_POLL: begin
                            if (r_poll_hit) begin
                                w_state    = S_ACC;
                                w_phase    = PH_STAT;
                                w_bus_read = 1'b1;
                                w_bus_addr = C_ADDR_STAT;
                            end else begin
                                w_poll_cnt = w_poll_inc;
                                if (w_poll_inc == C_POLL_MAX) begin
                                    w_go_stop    = 1'b1;
                                    w_st_timeout = 1'b1;
                                end else begin
                                    w_state    = S_POLL_WAIT;
                                    w_wait_cnt = '0;
                                end
                            end
                        end
                        default: begin
                            w_state = S_DONE;
                            w_st_ok = 1'b1;
                        end
                    endcase
                end
            end
            S_POLL_WAIT: begin
                if (w_abort_now) begin
                    w_go_stop    = 1'b1;
                    w_st_aborted = 1'b1;
                end else if (r_wait_cnt == C_GAP_LAST) begin
                    w_state    = S_ACC;
                    w_phase    = PH_POLL;
                    w_bus_read = 1'b1;
                    w_bus_addr = C_ADDR_CTRL;
                end else begin
                    w_wait_cnt = r_wait_cnt + WCW'(1);
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // Stop write: disable the frame and finish
        if (w_go_stop) begin
            w_state     = S_ACC;
            w_phase     = PH_STOP;
            w_bus_write = 1'b1;
            w_bus_read  = 1'b0;
            w_bus_addr  = C_ADDR_CTRL;
            w_bus_wdata = '0;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_phase          <= PH_WRITE;
            r_idx            <= '0;
            r_wait_cnt       <= '0;
            r_poll_cnt       <= '0;
            r_poll_hit       <= 1'b0;
            r_abort_pend     <= 1'b0;
            r_bus_read       <= 1'b0;
            r_bus_write      <= 1'b0;
            r_bus_addr       <= '0;
            r_bus_wdata      <= '0;
            r_st_ok          <= 1'b0;
            r_st_timeout     <= 1'b0;
            r_st_aborted     <= 1'b0;
            r_st_frame_error <= 1'b0;
            r_st_lock_out    <= 1'b0;
            r_st_clk_acc     <= '0;
        end else begin
            r_state          <= w_state;
            r_phase          <= w_phase;
            r_idx            <= w_idx;
            r_wait_cnt       <= w_wait_cnt;
            r_poll_cnt       <= w_poll_cnt;
            r_poll_hit       <= w_poll_hit;
            r_abort_pend     <= w_abort_pend;
            r_bus_read       <= w_bus_read;
            r_bus_write      <= w_bus_write;
            r_bus_addr       <= w_bus_addr;
            r_bus_wdata      <= w_bus_wdata;
            r_st_ok          <= w_st_ok;
            r_st_timeout     <= w_st_timeout;
            r_st_aborted     <= w_st_aborted;
            r_st_frame_error <= w_st_frame_error;
            r_st_lock_out    <= w_st_lock_out;
            r_st_clk_acc     <= w_st_clk_acc;
        end
    end

    assign busy            = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done            = (r_state == S_DONE);
    assign bus_read        = r_bus_read;
    assign bus_write       = r_bus_write;
    assign bus_address     = r_bus_addr;
    assign bus_write_data  = r_bus_wdata;
    assign st_ok           = r_st_ok;
    assign st_timeout      = r_st_timeout;
    assign st_aborted      = r_st_aborted;
    assign st_frame_error  = r_st_frame_error;
    assign st_lock_out     = r_st_lock_out;
    assign st_clk_accuracy = r_st_clk_acc;

endmodule
`default_nettype wire

// File: tb/tb_broadsync_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_broadsync_cfg_seq
// Purpose  : Self-checking bench for broadsync_cfg_seq with a CSR responder
//            that logs every completed access for comparison.
// Revision : 1.0 - initial release
// ============================================================================
module tb_broadsync_cfg_seq;

    typedef struct packed {
        logic        wr;
        logic [29:0] addr;
        logic [31:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic [29:0] cfg_toggle_frac_ns, cfg_toggle_ns, cfg_half_frac_ns, cfg_half_ns;
    logic [47:0] cfg_toggle_s, cfg_offset_s;
    logic        cfg_lock_value;
    logic [7:0]  cfg_clk_accuracy;
    logic        busy, done, st_ok, st_timeout, st_aborted, st_frame_error, st_lock_out;
    logic [7:0]  st_clk_accuracy;
    logic        bus_read, bus_write;
    logic [29:0] bus_address;
    logic [31:0] bus_write_data;
    logic [31:0] bus_read_data;
    logic        bus_access_complete;

    int          n_chk = 0;
    int          n_fail = 0;
    int          poll_n = 0;
    int          hit_at = 0;
    int          age = 0;
    int          done_cnt = 0;
    int          viol = 0;
    int          stab_err = 0;
    logic [31:0] stat_val = 32'h0;
    bit          slow6 = 1'b0;
    logic        held_v = 1'b0;
    logic [63:0] held = '0;
    txn_t        log_q[$];
    txn_t        exp_q[$];
    txn_t        exp_tab[15];

    broadsync_cfg_seq #(
        .FRAC_NS_WIDTH(30), .NS_WIDTH(30), .S_WIDTH(48), .POLL_GAP(2), .POLL_TIMEOUT(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_toggle_frac_ns(cfg_toggle_frac_ns), .cfg_toggle_ns(cfg_toggle_ns),
        .cfg_toggle_s(cfg_toggle_s), .cfg_half_frac_ns(cfg_half_frac_ns),
        .cfg_half_ns(cfg_half_ns), .cfg_offset_s(cfg_offset_s),
        .cfg_lock_value(cfg_lock_value), .cfg_clk_accuracy(cfg_clk_accuracy),
        .busy(busy), .done(done), .st_ok(st_ok), .st_timeout(st_timeout),
        .st_aborted(st_aborted), .st_frame_error(st_frame_error),
        .st_lock_out(st_lock_out), .st_clk_accuracy(st_clk_accuracy),
        .bus_read(bus_read), .bus_write(bus_write), .bus_address(bus_address),
        .bus_write_data(bus_write_data), .bus_read_data(bus_read_data),
        .bus_access_complete(bus_access_complete)
    );

    always #5 clk = ~clk;

    function automatic txn_t mk(input logic wr, input logic [29:0] a, input logic [31:0] d);
        txn_t t;
        t.wr = wr; t.addr = a; t.data = d;
        return t;
    endfunction

    // CSR responder: completes an access after 1 cycle (5 for the slowed addr 6 write)
    always @(posedge clk) begin
        if (reset) begin
            bus_access_complete <= 1'b0;
            bus_read_data       <= 32'h0;
            age                 <= 0;
        end else if (bus_access_complete) begin
            log_q.push_back(mk(bus_write, bus_address, bus_write ? bus_write_data : bus_read_data));
            bus_access_complete <= 1'b0;
            age                 <= 0;
        end else if (bus_read || bus_write) begin
            if (age >= (((slow6 && bus_write && bus_address == 30'd6)) ? 4 : 0)) begin
                bus_access_complete <= 1'b1;
                if (bus_read && bus_address == 30'd1) begin
                    bus_read_data <= (poll_n + 1 == hit_at) ? 32'h8000_0000 : 32'h0;
                    poll_n        <= poll_n + 1;
                end else if (bus_read && bus_address == 30'd14) begin
                    bus_read_data <= stat_val;
                end else begin
                    bus_read_data <= 32'h0;
                end
            end else begin
                age <= age + 1;
            end
        end else begin
            age <= 0;
        end
    end

    // Bus protocol watch: exclusive read/write, request held stable until complete
    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (reset) begin
            held_v <= 1'b0;
        end else begin
            if (bus_read && bus_write) viol <= viol + 1;
            if ((bus_read || bus_write) && held_v &&
                ({bus_read, bus_write, bus_address, bus_write_data} != held))
                stab_err <= stab_err + 1;
            if ((bus_read || bus_write) && !bus_access_complete) begin
                held_v <= 1'b1;
                held   <= {bus_read, bus_write, bus_address, bus_write_data};
            end else begin
                held_v <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic check_log(input int base, input string tag);
        chk({tag, "_count"}, 64'(log_q.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_txn%0d", tag, i),
                (base + i < log_q.size()) ? 64'(log_q[base + i]) : 64'hFFFF_FFFF_FFFF_FFFF,
                64'(exp_q[i]));
        end
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 1;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", n);
        end
    endtask

    task automatic wait_bus(input logic wr, input logic [29:0] a, input int limit);
        int k;
        k = 0;
        while (!((wr ? bus_write : bus_read) && bus_address == a) && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (k >= limit) begin
            n_chk++; n_fail++;
            $display("FAIL wait_bus: got no access to addr %0d, expected one", a);
        end
    endtask

    task automatic set_cfg_a();
        cfg_toggle_frac_ns = 30'h0ABC_DEF1;
        cfg_toggle_ns      = 30'h1234_5678;
        cfg_toggle_s       = 48'h0001_2345_6789;
        cfg_half_frac_ns   = 30'h155;
        cfg_half_ns        = 30'd500;
        cfg_offset_s       = 48'hBEEF_0000_1111;
        cfg_lock_value     = 1'b1;
        cfg_clk_accuracy   = 8'h21;
    endtask

    task automatic load_writes();
        exp_q.delete();
        for (int i = 0; i < 11; i++) exp_q.push_back(exp_tab[i]);
    endtask

    function automatic logic [63:0] flags();
        return 64'({st_ok, st_timeout, st_aborted, st_frame_error, st_lock_out, st_clk_accuracy});
    endfunction

    initial begin
        int base, dc, n, rb;

        exp_tab[0]  = mk(1'b1, 30'd1,  32'h0000_0000);
        exp_tab[1]  = mk(1'b1, 30'd2,  32'h0ABC_DEF1);
        exp_tab[2]  = mk(1'b1, 30'd3,  32'h1234_5678);
        exp_tab[3]  = mk(1'b1, 30'd4,  32'h2345_6789);
        exp_tab[4]  = mk(1'b1, 30'd5,  32'h0000_0001);
        exp_tab[5]  = mk(1'b1, 30'd6,  32'h0000_0155);
        exp_tab[6]  = mk(1'b1, 30'd7,  32'h0000_01F4);
        exp_tab[7]  = mk(1'b1, 30'd8,  32'h0000_1111);
        exp_tab[8]  = mk(1'b1, 30'd9,  32'h0000_BEEF);
        exp_tab[9]  = mk(1'b1, 30'd10, 32'h0000_0121);
        exp_tab[10] = mk(1'b1, 30'd1,  32'h0000_0001);
        exp_tab[11] = mk(1'b0, 30'd1,  32'h0000_0000);
        exp_tab[12] = mk(1'b0, 30'd1,  32'h0000_0000);
        exp_tab[13] = mk(1'b0, 30'd1,  32'h8000_0000);
        exp_tab[14] = mk(1'b0, 30'd14, 32'h0000_02A5);

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        set_cfg_a();
        repeat (3) @(negedge clk);
        chk("rst_bus", 64'({bus_read, bus_write, bus_address}), 64'd0);
        chk("rst_wdata", 64'(bus_write_data), 64'd0);
        chk("rst_ctrl", 64'({busy, done}), 64'd0);
        chk("rst_flags", flags(), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Normal run: hit on poll 3, status 0x2A5
        base = log_q.size(); dc = done_cnt;
        hit_at = poll_n + 3; stat_val = 32'h2A5;
        do_start();
        chk("first_req", 64'({bus_write, bus_read, bus_address, bus_write_data}),
            {1'b0, 1'b1, 1'b0, 30'd1, 32'd0});
        chk("busy_after_start", 64'(busy), 64'd1);
        wait_done(300, n);
        chk("done_latency", 64'(n), 64'd52);
        chk("busy_at_done", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        chk("ok_done_pulses", 64'(done_cnt - dc), 64'd1);
        exp_q.delete();
        for (int i = 0; i < 15; i++) exp_q.push_back(exp_tab[i]);
        check_log(base, "ok");
        chk("ok_flags", flags(), 64'({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5}));

        // Timeout: completion bit never set
        base = log_q.size(); hit_at = 0;
        do_start();
        chk("to_flags_cleared", flags(), 64'd0);
        wait_done(400, n);
        repeat (2) @(negedge clk);
        load_writes();
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b0, 30'd1, 32'h0));
        exp_q.push_back(mk(1'b1, 30'd1, 32'h0));
        check_log(base, "to");
        chk("to_flags", flags(), 64'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));

        // Abort during the slowed addr 6 write
        base = log_q.size(); slow6 = 1'b1;
        do_start();
        wait_bus(1'b1, 30'd6, 100);
        abort = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        wait_done(200, n);
        slow6 = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(exp_tab[i]);
        exp_q.push_back(mk(1'b1, 30'd1, 32'h0));
        check_log(base, "ab");
        chk("ab_flags", flags(), 64'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}));

        // Start while busy with different cfg: ignored, captured values used
        base = log_q.size(); dc = done_cnt;
        hit_at = poll_n + 1; stat_val = 32'h3FF;
        do_start();
        wait_bus(1'b1, 30'd4, 100);
        cfg_toggle_frac_ns = 30'h111_1111; cfg_toggle_ns = 30'h222_2222;
        cfg_toggle_s = 48'hFFFF_FFFF_FFFF; cfg_half_frac_ns = 30'h333;
        cfg_half_ns = 30'h444; cfg_offset_s = 48'h5555;
        cfg_lock_value = 1'b0; cfg_clk_accuracy = 8'h77;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(300, n);
        set_cfg_a();
        repeat (3) @(negedge clk);
        load_writes();
        exp_q.push_back(mk(1'b0, 30'd1, 32'h8000_0000));
        exp_q.push_back(mk(1'b0, 30'd14, 32'h3FF));
        check_log(base, "rs");
        chk("rs_done_pulses", 64'(done_cnt - dc), 64'd1);
        chk("rs_flags", flags(), 64'({1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF}));

        // Reset during a poll read, then a complete fresh run
        hit_at = poll_n + 1;
        do_start();
        wait_bus(1'b0, 30'd1, 100);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_ctrl", 64'({bus_read, bus_write, busy, done}), 64'd0);
        chk("rst_mid_flags", flags(), 64'd0);
        reset = 1'b0;
        rb = log_q.size();
        repeat (10) @(negedge clk);
        chk("rst_no_stop_write", 64'(log_q.size() - rb), 64'd0);
        chk("rst_bus_quiet", 64'({bus_read, bus_write}), 64'd0);
        base = log_q.size(); dc = done_cnt;
        hit_at = poll_n + 1; stat_val = 32'h2A5;
        do_start();
        chk("re_first_req", 64'({bus_write, bus_address, bus_write_data}), {1'b0, 1'b1, 30'd1, 32'd0});
        wait_done(300, n);
        repeat (3) @(negedge clk);
        load_writes();
        exp_q.push_back(mk(1'b0, 30'd1, 32'h8000_0000));
        exp_q.push_back(mk(1'b0, 30'd14, 32'h2A5));
        check_log(base, "re");
        chk("re_done_pulses", 64'(done_cnt - dc), 64'd1);
        chk("re_flags", flags(), 64'({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5}));

        chk("bus_rd_wr_exclusive", 64'(viol), 64'd0);
        chk("bus_req_stable", 64'(stab_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/broadsync_cfg_seq.md
# broadsync_cfg_seq

Hardware sequencer that programs one broadsync master/slave frame through the broadsync CSR bus. On a start pulse it disables the frame, writes the toggle time, half period, time-offset seconds and lock/accuracy registers, then enables the frame. It then polls for frame completion and reads back the received lock/accuracy/error status. It sits between the local timing controller and the CSR port of the broadsync register block, as the only master on that port.

## Interface
Parameters:
- FRAC_NS_WIDTH, 30, fractional-ns field width (≤32)
- NS_WIDTH, 30, nanosecond field width (≤32)
- S_WIDTH, 48, seconds field width (33..64)
- POLL_GAP, 16, idle cycles between completion polls (≥1)
- POLL_TIMEOUT, 1024, maximum number of completion polls (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  level; stops the running sequence
- cfg_toggle_frac_ns  in  FRAC_NS_WIDTH  toggle time, fractional ns
- cfg_toggle_ns  in  NS_WIDTH  toggle time, ns
- cfg_toggle_s  in  S_WIDTH  toggle time, seconds
- cfg_half_frac_ns  in  FRAC_NS_WIDTH  half period, fractional ns
- cfg_half_ns  in  NS_WIDTH  half period, ns
- cfg_offset_s  in  S_WIDTH  time offset, seconds
- cfg_lock_value  in  1  lock value to transmit
- cfg_clk_accuracy  in  8  clock accuracy to transmit
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at sequence end
- st_ok, st_timeout, st_aborted  out  1 each  outcome flags, mutually exclusive
- st_frame_error, st_lock_out  out  1 each  status read back
- st_clk_accuracy  out  8  status read back
- bus_read, bus_write  out  1 each  CSR request
- bus_address  out  30  word address [31:2]
- bus_write_data  out  32  write data
- bus_read_data  in  32  CSR read data
- bus_access_complete  in  1  CSR completion

## Operation
- All `cfg_*` inputs are captured into shadow registers on an accepted start. `start` while busy is ignored.
- Bus access (state ACC, then GAP):
  - Drive `bus_read` or `bus_write` with address and data, all registered and held stable until `bus_access_complete` is sampled high.
  - The request drops on the next cycle, which is the GAP cycle. `bus_access_complete` is ignored during GAP.
  - Only one of `bus_read` and `bus_write` is ever high.
- Write list, in order, with fields zero-extended to 32 bits:
  - addr 1 ← 0
  - addr 2 ← toggle_frac
  - addr 3 ← toggle_ns
  - addr 4 ← toggle_s[31:0]
  - addr 5 ← toggle_s[S_WIDTH-1:32]
  - addr 6 ← half_frac
  - addr 7 ← half_ns
  - addr 8 ← offset_s[31:0]
  - addr 9 ← offset_s[S_WIDTH-1:32]
  - addr 10 ← {lock, accuracy} in bits [8:0]
  - addr 1 ← 1
- States:
  - IDLE →(start) WRITE(idx 0..10) → POLL_WAIT
  - POLL_WAIT counts POLL_GAP cycles, then → POLL_RD, which reads addr 1.
  - POLL_RD: if read data bit31 = 1 → STAT_RD. Otherwise poll_cnt+1; if poll_cnt = POLL_TIMEOUT → STOP_WR (timeout), else → POLL_WAIT.
  - STAT_RD reads addr 14 and latches st_clk_accuracy = [7:0], st_lock_out = [8], st_frame_error = [9] → DONE (st_ok).
  - STOP_WR writes addr 1 ← 0 → DONE.
  - DONE pulses `done` → IDLE.
- Abort:
  - Sampled in every non-IDLE state.
  - An in-flight access completes first, then → STOP_WR with st_aborted.
  - Abort during STOP_WR or DONE has no effect.
- Outcome flags and status are cleared on accepted start and hold their value after done.
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset mid-access drops the request on the next edge; no stop write is issued.

## Timing
- Access: request high at cycle t, complete sampled at t+1, GAP at t+2, next request at t+3. Each access takes 3 cycles when complete arrives one cycle after the request.
- First write request appears 1 cycle after start is sampled.
- The 11 writes take 33 cycles. Each poll costs POLL_GAP + 3 cycles.
- done asserts 1 cycle after the final access GAP. busy falls in the same cycle done rises.
- A complete arriving late simply extends ACC; there is no bus timeout.

## Test plan
- Start with toggle_s=0x1_2345_6789, half_ns=500, accuracy=0x21, lock=1, CSR model completes after 1 cycle → writes in the listed order with addr 5 = 0x1, addr 10 = 0x121, last addr 1 = 0x1. Set bit31 on poll 3, addr 14 returns 0x2A5 → st_ok=1, st_frame_error=1, st_lock_out=0, st_clk_accuracy=0xA5, one done pulse.
- POLL_TIMEOUT=4, bit31 never set → exactly 4 reads of addr 1, then write addr 1 ← 0, st_timeout=1, no addr 14 read.
- Abort asserted while the addr 6 write is pending with complete delayed 5 cycles → addr 6 finishes, next access is write addr 1 ← 0, st_aborted=1.
- Start pulsed while busy, with cfg inputs changed → ignored; written values match the originally captured config.
- Reset asserted in the middle of a poll read → bus_read=0, busy=0, all flags 0 next cycle. A later start runs the full sequence from addr 1.
